matrix_transpose_stream: RTL and testbench
==========================================

Name: matrix_transpose_stream

Overview:
- Streaming, parametrised successor to the array-port matrix transpose in the attention datapath.
- Accepts an N x D signed matrix as a row-major element stream and emits its D x N transpose as a row-major stream.
- Uses ping-pong buffering so loading matrix k+1 overlaps draining matrix k.
- Per-matrix mode selects transpose or pass-through. Feeds the K^T path ahead of the QK^T multiplier.

Parameters:
N, 3, input rows (>=1)
D, 4, input columns (>=1)
WIDTH, 8, element width in bits (signed)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-low reset (0 = reset)
mode_transpose  input  1  1 = transpose, 0 = pass-through; sampled with the first element of each matrix
in_valid  input  1  input element valid
in_ready  output  1  input element accepted when in_valid && in_ready
in_data  input  WIDTH  signed input element, row-major
in_last  input  1  marks final element of input matrix (checked only)
out_valid  output  1  output element valid
out_ready  input  1  downstream ready
out_data  output  WIDTH  signed output element
out_last  output  1  final element of output matrix
busy  output  1  any bank full or partial matrix loaded
len_err  output  1  sticky in_last/length mismatch flag

Behaviour:
- Reset (reset==0 at a rising edge): both banks empty; write/read bank pointers = 0; all counters = 0; in_ready=1 the following cycle; out_valid=0, out_last=0, busy=0, len_err=0, out_data=0. Partial or full matrices in flight are discarded.
- Storage: two banks of N*D x WIDTH registers. Flags full[1:0] and mode_b[1:0] are stored per bank.
- Write side:
  - in_ready = !full[wr_bank] (registered-flag based; no combinational path from out_ready).
  - On each accept: store in_data at index wr_cnt (0..N*D-1).
  - When wr_cnt==0, latch mode_transpose into mode_b[wr_bank].
  - On accepting index N*D-1: set full[wr_bank], toggle wr_bank, wr_cnt=0.
- Length is defined by count only.
  - len_err sets if in_last=1 on an accepted element with wr_cnt != N*D-1, or in_last=0 on an accepted element with wr_cnt == N*D-1.
  - len_err stays set until reset. Data flow is unaffected.
- Read side:
  - out_valid = full[rd_bank].
  - Output counters: oc (0..N-1, inner) and orow (0..D-1, outer).
  - Transpose: out_data = bank[rd_bank][oc*D + orow].
  - Pass-through: out_data = bank[rd_bank][linear count].
  - out_last = out_valid && final element.
  - Advance only on out_valid && out_ready. On the final handshake: clear full[rd_bank], toggle rd_bank, counters = 0.
- Stall: while out_valid && !out_ready, out_data and out_last hold stable.
- Latency: out_valid rises the cycle after the edge that accepts input element N*D-1. Throughput is 1 element/cycle on each side.
- Freed bank: in_ready re-asserts the cycle after the final output handshake on that bank.
- Simultaneous events:
  - A write completing into one bank and a read completing on the other in the same cycle both take effect; flags update independently.
  - Both banks full: in_ready=0.
  - Both banks empty: out_valid=0.
- busy = full[0] | full[1] | (wr_cnt != 0).
- Boundary: N*D==1 makes transpose and pass-through identical; out_last=1 on every output.
- Width: data is stored and forwarded unmodified, with no arithmetic or sign change.

Test Plan:
- Transpose, free-flowing: reset, mode=1, stream 1..12 (in_last on 12), out_ready=1. Required output is 1,5,9,2,6,10,3,7,11,4,8,12, with out_last only on 12. out_valid rises 1 cycle after 12 is accepted. len_err=0.
- Pass-through: mode=0, stream 1..12. Output is 1..12 in order.
- Back-to-back: matrix A (1..12, mode=1) then B (13..24, mode=0), out_ready=0.
  - in_ready drops after 24 is accepted and busy=1.
  - Then out_ready=1: A is emitted transposed, then B is emitted 13..24.
  - in_ready returns 1 the cycle after A's last output.
- Backpressure: out_ready toggled 1,0,1,0. out_data/out_last are stable during each stall, with no duplicates or drops. The sequence matches the first test.
- Length error: in_last on element 6. len_err=1 from the next cycle and stays 1. All 12 outputs are still produced correctly. Reset clears len_err.
- Reset mid-drain: assert reset after 5 outputs. Next cycle out_valid=0, in_ready=1, busy=0. A fresh matrix then transposes correctly.

Source files
------------

// File: rtl/matrix_transpose_stream.sv
// -----------------------------------------------------------------------------
// matrix_transpose_stream
//
// Streaming matrix transpose with ping-pong buffering. An N x D signed matrix
// arrives as a row-major element stream and leaves as its D x N transpose,
// also row-major. Each matrix may instead be passed through unchanged. One
// bank fills while the other drains, so throughput is one element per cycle
// on each side.
//
// Ports:
//   clk             rising-edge clock for all logic
//   reset           synchronous active-low reset (0 = reset)
//   mode_transpose  1 = transpose, 0 = pass-through; taken with first element
//   in_valid        input element valid
//   in_ready        input element accepted when in_valid && in_ready
//   in_data         signed input element, row-major
//   in_last         end-of-matrix marker, only checked against the count
//   out_valid       output element valid
//   out_ready       downstream ready
//   out_data        signed output element (0 while out_valid is low)
//   out_last        final element of the output matrix
//   busy            any bank full or a partial matrix loaded
//   len_err         sticky in_last / element-count mismatch
// -----------------------------------------------------------------------------
module matrix_transpose_stream #(
    parameter int N     = 3,
    parameter int D     = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode_transpose,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    len_err
);

    localparam int TOTAL = N * D;
    localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int NW    = (N > 1) ? $clog2(N) : 1;
    localparam int DW    = (D > 1) ? $clog2(D) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);
    localparam logic [NW-1:0] LAST_OC  = NW'(N - 1);

    logic signed [WIDTH-1:0] mem [2][TOTAL];

    logic [1:0]    full;
    logic [1:0]    full_next;
    logic [1:0]    mode_b;
    logic          wr_bank;
    logic          rd_bank;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] rd_idx;
    logic [NW-1:0] oc;
    logic [DW-1:0] orow;

    logic wr_fire;
    logic wr_done;
    logic rd_fire;
    logic rd_done;

    // Handshake qualifiers. Both ready/valid come from registered flags only,
    // so there is no combinational path from out_ready to in_ready.
    assign in_ready  = !full[wr_bank];
    assign wr_fire   = in_valid && in_ready;
    assign wr_done   = wr_fire && (wr_cnt == LAST_IDX);

    assign out_valid = full[rd_bank];
    assign rd_fire   = out_valid && out_ready;
    assign rd_done   = rd_fire && (rd_cnt == LAST_IDX);

    assign busy      = (|full) || (wr_cnt != '0);

    // Read address: a transposed matrix walks down the stored columns
    // (oc selects the stored row, orow the stored column); pass-through
    // simply follows the linear count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rd_idx = rd_cnt;
        if (mode_b[rd_bank]) begin
            rd_idx = CW'(int'(oc) * D + int'(orow));
        end
    end

    assign out_data = out_valid ? mem[rd_bank][rd_idx] : '0;
    assign out_last = out_valid && (rd_cnt == LAST_IDX);

    // Bank flags. A bank can only be written while empty and only read while
    // full, so a completing write and a completing read always touch
    // different banks and both updates can be applied independently.
    always_comb begin
        full_next = full;
        if (wr_done) full_next[wr_bank] = 1'b1;
        if (rd_done) full_next[rd_bank] = 1'b0;
    end

    // NOTE: the element storage has no reset. Stale contents are unreachable
    // because reads are gated by the full flags and out_data is forced to 0
    // while out_valid is low, so resetting the array would buy nothing.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_cnt] <= in_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full    <= '0;
            mode_b  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            oc      <= '0;
            orow    <= '0;
            len_err <= 1'b0;
        end else begin
            full <= full_next;

            if (wr_fire) begin
                if (wr_cnt == '0) begin
                    mode_b[wr_bank] <= mode_transpose;
                end
                if (wr_done) begin
                    wr_bank <= ~wr_bank;
                    wr_cnt  <= '0;
                end else begin
                    wr_cnt  <= wr_cnt + 1'b1;
                end
                // Matrix length is defined by count; in_last is only audited.
                if (in_last != (wr_cnt == LAST_IDX)) begin
                    len_err <= 1'b1;
                end
            end

            if (rd_fire) begin
                if (rd_done) begin
                    rd_bank <= ~rd_bank;
                    rd_cnt  <= '0;
                    oc      <= '0;
                    orow    <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (oc == LAST_OC) begin
                        oc   <= '0;
                        orow <= orow + 1'b1;
                    end else begin
                        oc   <= oc + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// -----------------------------------------------------------------------------
// tb_matrix_transpose_stream
//
// Directed self-checking bench for matrix_transpose_stream with N=3, D=4,
// WIDTH=8. Inputs change 1 time unit after a rising edge; outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_matrix_transpose_stream;

    localparam int N     = 3;
    localparam int D     = 4;
    localparam int WIDTH = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    mode_transpose;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_last;
    logic                    busy;
    logic                    len_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Hand-computed transpose of the 3x4 matrix 1..12 (row-major).
    int exp_t [12] = '{1, 5, 9, 2, 6, 10, 3, 7, 11, 4, 8, 12};

    logic ov_before_last;
    logic le_hist [12];

    matrix_transpose_stream #(.N(N), .D(D), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .mode_transpose (mode_transpose),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .len_err        (len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Stream base..base+11 with in_last asserted on element index last_pos.
    task automatic send(input int base, input logic mode, input int last_pos);
        int guard;
        for (int i = 0; i < 12; i++) begin
            in_valid       = 1'b1;
            in_data        = WIDTH'(base + i);
            in_last        = (i == last_pos);
            mode_transpose = mode;
            guard          = 0;
            @(negedge clk);
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            total_cnt++;
            if (in_ready !== 1'b1) begin
                $display("FAIL send_wait[%0d]: in_ready=%b, required 1 within 50 cycles", i, in_ready);
            end else begin
                pass_cnt++;
            end
            if (i == 11) ov_before_last = out_valid;
            @(posedge clk);
            #1;
            le_hist[i] = len_err;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drain output elements first..first+count-1 of one matrix. tr selects
    // the transposed or linear expectation; stall inserts one not-ready cycle
    // before each handshake and checks the held element.
    task automatic drain(input logic tr, input int base, input logic stall,
                         input int first, input int count);
        int               guard;
        logic [WIDTH-1:0] exp_d;
        logic             exp_l;
        for (int k = first; k < first + count; k++) begin
            exp_d = tr ? WIDTH'(exp_t[k] + base - 1) : WIDTH'(base + k);
            exp_l = (k == 11);
            if (stall) begin
                out_ready = 1'b0;
                @(negedge clk);
                total_cnt++;
                if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== exp_l) begin
                    $display("FAIL stall[%0d]: valid=%b data=%0d last=%b, required valid=1 data=%0d last=%b",
                             k, out_valid, out_data, out_last, $signed(exp_d), exp_l);
                end else begin
                    pass_cnt++;
                end
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            guard     = 0;
            @(negedge clk);
            while (!out_valid && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== exp_l) begin
                $display("FAIL drain[%0d]: valid=%b data=%0d last=%b, required valid=1 data=%0d last=%b",
                         k, out_valid, out_data, out_last, $signed(exp_d), exp_l);
            end else begin
                pass_cnt++;
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        total_cnt++;
        if ({in_ready, out_valid, out_last, busy, len_err} !== 5'b10000) begin
            $display("FAIL reset_flags: ready,valid,last,busy,err=%b, required 10000",
                     {in_ready, out_valid, out_last, busy, len_err});
        end else begin
            pass_cnt++;
        end
        total_cnt++;
        if (out_data !== '0) begin
            $display("FAIL reset_data: out_data=%0d, required 0", out_data);
        end else begin
            pass_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_transpose();
        send(1, 1'b1, 11);
        total_cnt++;
        if (ov_before_last !== 1'b0) begin
            $display("FAIL early_valid: out_valid=%b before last accept, required 0", ov_before_last);
        end else begin
            pass_cnt++;
        end
        total_cnt++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || len_err !== 1'b0) begin
            $display("FAIL latency: valid=%b ready=%b err=%b after last accept, required 1 1 0",
                     out_valid, in_ready, len_err);
        end else begin
            pass_cnt++;
        end
        drain(1'b1, 1, 1'b0, 0, 12);
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL idle_after_t: valid=%b busy=%b, required 0 0", out_valid, busy);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_passthrough();
        send(1, 1'b0, 11);
        drain(1'b0, 1, 1'b0, 0, 12);
        total_cnt++;
        if (len_err !== 1'b0) begin
            $display("FAIL pass_len_err: len_err=%b, required 0", len_err);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(1, 1'b1, 11);
        send(13, 1'b0, 11);
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
            $display("FAIL both_full: ready=%b busy=%b valid=%b, required 0 1 1",
                     in_ready, busy, out_valid);
        end else begin
            pass_cnt++;
        end
        drain(1'b1, 1, 1'b0, 0, 11);
        total_cnt++;
        if (in_ready !== 1'b0) begin
            $display("FAIL ready_early: in_ready=%b before A last output, required 0", in_ready);
        end else begin
            pass_cnt++;
        end
        drain(1'b1, 1, 1'b0, 11, 1);
        total_cnt++;
        if (in_ready !== 1'b1) begin
            $display("FAIL ready_freed: in_ready=%b after A last output, required 1", in_ready);
        end else begin
            pass_cnt++;
        end
        drain(1'b0, 13, 1'b0, 0, 12);
        total_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL idle_after_b2b: busy=%b valid=%b, required 0 0", busy, out_valid);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        send(1, 1'b1, 11);
        drain(1'b1, 1, 1'b1, 0, 12);
    endtask

    task automatic test_len_err();
        send(1, 1'b1, 5);
        total_cnt++;
        if (le_hist[4] !== 1'b0 || le_hist[5] !== 1'b1 || le_hist[11] !== 1'b1) begin
            $display("FAIL len_err_set: after elem5=%b elem6=%b elem12=%b, required 0 1 1",
                     le_hist[4], le_hist[5], le_hist[11]);
        end else begin
            pass_cnt++;
        end
        drain(1'b1, 1, 1'b0, 0, 12);
        total_cnt++;
        if (len_err !== 1'b1) begin
            $display("FAIL len_err_sticky: len_err=%b, required 1", len_err);
        end else begin
            pass_cnt++;
        end
        apply_reset();
        total_cnt++;
        if (len_err !== 1'b0) begin
            $display("FAIL len_err_clear: len_err=%b after reset, required 0", len_err);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_drain();
        send(1, 1'b1, 11);
        drain(1'b1, 1, 1'b0, 0, 5);
        apply_reset();
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== '0) begin
            $display("FAIL mid_reset: valid=%b ready=%b busy=%b data=%0d, required 0 1 0 0",
                     out_valid, in_ready, busy, out_data);
        end else begin
            pass_cnt++;
        end
        @(posedge clk);
        #1;
        // Fresh matrix -6..5 also exercises negative values.
        send(-6, 1'b1, 11);
        drain(1'b1, -6, 1'b0, 0, 12);
    endtask

    initial begin
        reset          = 1'b0;
        mode_transpose = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        in_last        = 1'b0;
        out_ready      = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_transpose();
        test_passthrough();
        test_back_to_back();
        test_backpressure();
        test_len_err();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
